// File: rtl/gonso_seq_pkg.sv
// gonso_seq_pkg: shared widths, register offsets, bit indices and FSM states for the gonso sequencer
package gonso_seq_pkg;
  localparam int DATA_W = 20;
  localparam logic [31:0] REG_CTRL     = 32'h00;
  localparam logic [31:0] REG_STATUS   = 32'h04;
  localparam logic [31:0] REG_IN_DATA  = 32'h08;
  localparam logic [31:0] REG_OUT_DATA = 32'h0C;
  localparam logic [31:0] REG_JOBCNT   = 32'h10;
  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_IN_FULL  = 2;
  localparam int ST_OVERFLOW = 3;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;
endpackage

// File: rtl/gonso_seq_fifo.sv
// gonso_seq_fifo: synchronous FIFO with flush; push ignored when full, pop ignored when empty
// Ports: clk, rst_n, push/din, pop/dout (head), flush, full, empty, count
module gonso_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/gonso_sequencer.sv
// gonso_sequencer: Wishbone-mapped job sequencer streaming queued operands through the gonso datapath
// Ports: clk, rst_n (async, active-low); wbs_* Wishbone slave (registered rdata, 1-cycle ack);
//        dp_input/dp_output datapath stream; irq = done & irq_en
module gonso_sequencer
  import gonso_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h30030100,
  parameter int DEPTH = 8,
  parameter int DP_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] dp_input,
  input  logic [DATA_W-1:0] dp_output,
  output logic              irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state, state_nx;
  logic acc, wr, rd, start, clear, in_push, out_pop, issue, cap, done_set;
  logic done, ovf, irq_en, unused_bits;
  logic [31:0] off, rdata, status;
  logic [DATA_W-1:0] in_dout, out_dout;
  logic in_full, in_empty, out_full, out_empty;
  logic [CW-1:0] in_count, out_count;
  // Bit 0 tracks the item currently on dp_input, so the tail lines up with dp_output
  // arriving DP_LATENCY cycles after dp_input changes.
  logic [DP_LATENCY:0] vld;
  logic [4:0] inflight;
  logic [5:0] used;
  logic [15:0] jobcnt;
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:20], out_full};
  assign acc = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign off = wbs_adr_i - BASE_ADDR;
  assign wr = acc & wbs_we_i & wbs_sel_i[0];
  assign rd = acc & ~wbs_we_i;
  assign start = wr && off == REG_CTRL && wbs_dat_i[CTRL_START];
  assign clear = wr && off == REG_CTRL && wbs_dat_i[CTRL_CLEAR];
  assign in_push = wr && off == REG_IN_DATA;
  assign out_pop = rd && off == REG_OUT_DATA;
  assign cap = vld[DP_LATENCY];
  assign irq = done & irq_en;
  gonso_seq_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_in (
    .clk, .rst_n, .push(in_push), .pop(issue), .flush(clear), .din(wbs_dat_i[DATA_W-1:0]),
    .dout(in_dout), .full(in_full), .empty(in_empty), .count(in_count)
  );
  gonso_seq_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_out (
    .clk, .rst_n, .push(cap), .pop(out_pop), .flush(clear), .din(dp_output),
    .dout(out_dout), .full(out_full), .empty(out_empty), .count(out_count)
  );
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= DP_LATENCY; i++) inflight = inflight + 5'(vld[i]);
    // Reserving result slots for in-flight items keeps the result queue from overflowing.
    used = 6'(out_count) + 6'(inflight);
    issue = state == S_ISSUE && !in_empty && used < 6'(DEPTH);
    done_set = state == S_DRAIN && vld == '0 && !clear;
    state_nx = clear ? S_IDLE
             : (state == S_IDLE && start && !in_empty) ? S_ISSUE
             : (state == S_ISSUE && in_empty && !in_push) ? S_DRAIN
             : (state == S_DRAIN && vld == '0) ? S_IDLE
             : state;
  end
  always_comb begin
    status = '0;
    status[ST_BUSY] = state != S_IDLE;
    status[ST_DONE] = done;
    status[ST_IN_FULL] = in_full;
    status[ST_OVERFLOW] = ovf;
    status[7:4] = 4'(in_count);
    status[11:8] = 4'(out_count);
    rdata = off == REG_CTRL ? {29'b0, irq_en, 2'b0}
          : off == REG_STATUS ? status
          : (off == REG_OUT_DATA && !out_empty) ? {{(32-DATA_W){1'b0}}, out_dout}
          : off == REG_JOBCNT ? {16'b0, jobcnt}
          : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      dp_input <= '0;
      vld <= '0;
      jobcnt <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      if (rd) wbs_dat_o <= rdata;
      vld <= clear ? '0 : {vld[DP_LATENCY-1:0], issue};
      dp_input <= clear ? '0 : issue ? in_dout : dp_input;
      jobcnt <= clear ? '0 : jobcnt + 16'(cap);
      done <= clear ? 1'b0 : done_set ? 1'b1
            : (wr && off == REG_STATUS && wbs_dat_i[ST_DONE]) ? 1'b0 : done;
      ovf <= clear ? 1'b0 : (in_push && in_full) ? 1'b1
           : (wr && off == REG_STATUS && wbs_dat_i[ST_OVERFLOW]) ? 1'b0 : ovf;
      if (wr && off == REG_CTRL) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
    end
endmodule
